// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard.
//   lc3b_reg      : 3-bit architectural register index (R0-R7)
//   lc3b_control  : subset of the decode control word consumed here
//   sb_state_t    : branch-shadow FSM states
//   R7            : link register index (JSR/TRAP destination)
//   eff_dest()    : destination after the R7 override
package issue_scoreboard_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic uses_sr1;
    logic uses_sr2;
    logic load_regfile;
    logic dest_mux_sel;
    logic branch;
  } lc3b_control;

  typedef enum logic [0:0] {
    SB_IDLE    = 1'b0,
    SB_BR_WAIT = 1'b1
  } sb_state_t;

  localparam lc3b_reg R7 = 3'd7;

  // JSR/TRAP select the link register regardless of the encoded dest field.
  function automatic lc3b_reg eff_dest(input lc3b_control ctrl, input lc3b_reg dest);
    return ctrl.dest_mux_sel ? R7 : dest;
  endfunction

endpackage

// File: rtl/issue_scoreboard_reg_counter.sv
// sb_reg_counter: pending-write counter for one architectural register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   inc, dec   : issue of a writer / retirement of a writer
//   is_zero    : no writes pending
//   is_max     : counter saturated (further writers must wait)
//   underflow  : retirement seen while nothing was pending (comb)
module sb_reg_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic is_max,
  output logic underflow
);

  logic [CNT_W-1:0] cnt_q;

  assign is_zero   = (cnt_q == '0);
  assign is_max    = &cnt_q;
  assign underflow = dec & is_zero;

  // Simultaneous inc and dec cancel. A lone dec at zero holds at zero;
  // a lone inc at max holds at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && !dec && !is_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decides whether the decode-stage instruction may issue.
// Tracks in-flight register writes per register and holds fetch while an
// issued branch is unresolved.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   id_valid, id_ctrl   : decode instruction present and its control word
//   id_sr1/id_sr2/id_dest : decode register indices
//   wb_valid, wb_load_regfile, wb_dest : writeback retirement report
//   br_resolve          : one-cycle pulse, outstanding branch resolved
//   issue, stall_id     : combinational issue decision
//   fetch_hold          : branch shadow active (state decode)
//   sb_err              : sticky retirement-with-nothing-pending flag
//   state               : FSM state, exported for observation
//   stall_cycles        : saturating stall counter (SCOREBOARD_STATS_EN only)
// Optional feature macro: SCOREBOARD_STATS_EN
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W  = 2
`ifdef SCOREBOARD_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  lc3b_control id_ctrl,
  input  lc3b_reg     id_sr1,
  input  lc3b_reg     id_sr2,
  input  lc3b_reg     id_dest,
  input  logic        wb_valid,
  input  logic        wb_load_regfile,
  input  lc3b_reg     wb_dest,
  input  logic        br_resolve,
  output logic        issue,
  output logic        stall_id,
  output logic        fetch_hold,
  output logic        sb_err,
  output sb_state_t   state
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles
`endif
);

  logic [7:0] inc_vec;
  logic [7:0] dec_vec;
  logic [7:0] zero_vec;
  logic [7:0] max_vec;
  logic [7:0] uf_vec;
  lc3b_reg    dest_eff;
  logic       hazard;
  sb_state_t  state_q;

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_cnt
      sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_vec[g]),
        .dec       (dec_vec[g]),
        .is_zero   (zero_vec[g]),
        .is_max    (max_vec[g]),
        .underflow (uf_vec[g])
      );
    end
  endgenerate

  assign dest_eff = eff_dest(id_ctrl, id_dest);

  // Sources must have nothing pending (no writeback bypass); a writer only
  // needs room in its destination counter.
  assign hazard = (id_ctrl.uses_sr1     & ~zero_vec[id_sr1])
                | (id_ctrl.uses_sr2     & ~zero_vec[id_sr2])
                | (id_ctrl.load_regfile &  max_vec[dest_eff]);

  // Handshake: id_valid is the decode-side valid; issue is the accept.
  // The instruction transfers exactly in a cycle with id_valid & issue;
  // while stall_id is high decode must hold its instruction unchanged.
  assign stall_id   = id_valid & (hazard | (state_q == SB_BR_WAIT));
  assign issue      = id_valid & ~stall_id;
  assign fetch_hold = (state_q == SB_BR_WAIT);
  assign state      = state_q;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < 8; i++) begin
      inc_vec[i] = issue & id_ctrl.load_regfile & (dest_eff == lc3b_reg'(i));
      dec_vec[i] = wb_valid & wb_load_regfile & (wb_dest == lc3b_reg'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_IDLE;
    end else begin
      case (state_q)
        SB_IDLE:    if (issue && id_ctrl.branch) state_q <= SB_BR_WAIT;
        SB_BR_WAIT: if (br_resolve)              state_q <= SB_IDLE;
        default:                                 state_q <= SB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (|uf_vec) begin
      sb_err <= 1'b1;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_id && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, reset corner sequence,
// random traffic against a rule-level model, optional stall statistics.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid = 1'b0;
  lc3b_control id_ctrl  = '0;
  lc3b_reg     id_sr1   = '0;
  lc3b_reg     id_sr2   = '0;
  lc3b_reg     id_dest  = '0;
  logic        wb_valid = 1'b0;
  logic        wb_load_regfile = 1'b0;
  lc3b_reg     wb_dest  = '0;
  logic        br_resolve = 1'b0;
  logic        issue, stall_id, fetch_hold, sb_err;
  sb_state_t   state;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  issue_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_ctrl         (id_ctrl),
    .id_sr1          (id_sr1),
    .id_sr2          (id_sr2),
    .id_dest         (id_dest),
    .wb_valid        (wb_valid),
    .wb_load_regfile (wb_load_regfile),
    .wb_dest         (wb_dest),
    .br_resolve      (br_resolve),
    .issue           (issue),
    .stall_id        (stall_id),
    .fetch_hold      (fetch_hold),
    .sb_err          (sb_err),
    .state           (state)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic lc3b_control ctl(input logic u1, input logic u2, input logic ld,
                                      input logic dm, input logic br);
    lc3b_control c;
    c.uses_sr1 = u1; c.uses_sr2 = u2; c.load_regfile = ld;
    c.dest_mux_sel = dm; c.branch = br;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; id_valid = 1'b0; wb_valid = 1'b0; br_resolve = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    lc3b_control c;
    lc3b_reg     s1, s2, d;
    logic        wv, wl;
    lc3b_reg     wd;
    logic        br;
    logic        e_iss, e_stl, e_fh, e_err;
  } vec_t;

  function automatic vec_t row(input logic v, input lc3b_control c, input lc3b_reg s1,
                               input lc3b_reg s2, input lc3b_reg d, input logic wv,
                               input lc3b_reg wd, input logic br, input logic e_iss,
                               input logic e_stl, input logic e_fh, input logic e_err);
    vec_t r;
    r.v = v; r.c = c; r.s1 = s1; r.s2 = s2; r.d = d;
    r.wv = wv; r.wl = wv; r.wd = wd; r.br = br;
    r.e_iss = e_iss; r.e_stl = e_stl; r.e_fh = e_fh; r.e_err = e_err;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    id_valid = r.v; id_ctrl = r.c; id_sr1 = r.s1; id_sr2 = r.s2; id_dest = r.d;
    wb_valid = r.wv; wb_load_regfile = r.wl; wb_dest = r.wd; br_resolve = r.br;
  endtask

  // ---------------- reference model ----------------
  int m_cnt[8];
  bit m_brw;
  bit m_err;

  localparam int MAXC = 3;

  task automatic model_clear();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_brw = 0;
    m_err = 0;
  endtask

  vec_t tbl[26];
  lc3b_control c_none, c_wr, c_rd1, c_jsr, c_br;

  initial begin
    c_none = ctl(0, 0, 0, 0, 0);
    c_wr   = ctl(0, 0, 1, 0, 0);
    c_rd1  = ctl(1, 0, 0, 0, 0);
    c_jsr  = ctl(0, 0, 1, 1, 1);
    c_br   = ctl(0, 0, 0, 0, 1);

    //               v  ctrl            s1 s2 d  wv wd br   iss stl fh err
    tbl[0]  = row(1, ctl(1,1,1,0,0),    0, 0, 1, 0, 0, 0,   1, 0, 0, 0);
    tbl[1]  = row(1, c_rd1,             1, 0, 4, 0, 0, 0,   0, 1, 0, 0);
    tbl[2]  = row(1, c_rd1,             1, 0, 4, 1, 1, 0,   0, 1, 0, 0);
    tbl[3]  = row(1, c_rd1,             1, 0, 4, 0, 0, 0,   1, 0, 0, 0);
    tbl[4]  = row(1, c_wr,              0, 0, 2, 0, 0, 0,   1, 0, 0, 0);
    tbl[5]  = row(1, c_wr,              0, 0, 2, 1, 2, 0,   1, 0, 0, 0);
    tbl[6]  = row(1, c_rd1,             2, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    tbl[7]  = row(0, c_none,            0, 0, 0, 1, 2, 0,   0, 0, 0, 0);
    tbl[8]  = row(1, c_wr,              0, 0, 3, 0, 0, 0,   1, 0, 0, 0);
    tbl[9]  = row(1, c_wr,              0, 0, 3, 0, 0, 0,   1, 0, 0, 0);
    tbl[10] = row(1, c_wr,              0, 0, 3, 0, 0, 0,   1, 0, 0, 0);
    tbl[11] = row(1, c_wr,              0, 0, 3, 1, 3, 0,   0, 1, 0, 0);
    tbl[12] = row(1, c_wr,              0, 0, 3, 0, 0, 0,   1, 0, 0, 0);
    tbl[13] = row(0, c_none,            0, 0, 0, 1, 3, 0,   0, 0, 0, 0);
    tbl[14] = row(0, c_none,            0, 0, 0, 1, 3, 0,   0, 0, 0, 0);
    tbl[15] = row(0, c_none,            0, 0, 0, 1, 3, 0,   0, 0, 0, 0);
    tbl[16] = row(1, c_jsr,             0, 0, 2, 0, 0, 0,   1, 0, 0, 0);
    tbl[17] = row(1, c_none,            0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    tbl[18] = row(1, c_none,            0, 0, 0, 0, 0, 1,   0, 1, 1, 0);
    tbl[19] = row(1, c_rd1,             7, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    tbl[20] = row(0, c_none,            0, 0, 0, 1, 7, 0,   0, 0, 0, 0);
    tbl[21] = row(0, c_none,            0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    tbl[22] = row(1, c_rd1,             7, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    tbl[23] = row(0, c_none,            0, 0, 0, 1, 5, 0,   0, 0, 0, 0);
    tbl[24] = row(0, c_none,            0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    tbl[25] = row(0, c_none,            0, 0, 0, 0, 0, 0,   0, 0, 0, 1);

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_issue", issue, 0);
    chk("rst_stall", stall_id, 0);
    chk("rst_fetch_hold", fetch_hold, 0);
    chk("rst_sb_err", sb_err, 0);
    chk("rst_state", state, SB_IDLE);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_issue", i), issue, tbl[i].e_iss);
      chk($sformatf("row%0d_stall", i), stall_id, tbl[i].e_stl);
      chk($sformatf("row%0d_fetch_hold", i), fetch_hold, tbl[i].e_fh);
      chk($sformatf("row%0d_sb_err", i), sb_err, tbl[i].e_err);
    end

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    drive(row(1, c_wr, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(row(1, c_br, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    // Busy inputs during reset must not leave any trace.
    drive(row(1, c_wr, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_fetch_hold", fetch_hold, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(row(0, c_none, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("midrst_fetch_hold", fetch_hold, 0);
    chk("midrst_sb_err", sb_err, 0);
    chk("midrst_state", state, SB_IDLE);
    @(negedge clk);
    drive(row(1, ctl(1, 1, 0, 0, 0), 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("midrst_reader_issue", issue, 1);
    chk("midrst_reader_stall", stall_id, 0);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    model_clear();
    for (int n = 0; n < 600; n++) begin
      int pend[$];
      lc3b_reg ed;
      bit haz, m_stall, m_iss, wr_inc, wr_dec;
      @(negedge clk);
      id_valid = ($urandom_range(0, 3) != 0);
      id_ctrl  = ctl($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      id_sr1   = lc3b_reg'($urandom_range(0, 7));
      id_sr2   = lc3b_reg'($urandom_range(0, 7));
      id_dest  = lc3b_reg'($urandom_range(0, 7));
      wb_valid = $urandom_range(0, 1);
      wb_load_regfile = ($urandom_range(0, 4) != 0);
      pend = {};
      for (int r = 0; r < 8; r++) if (m_cnt[r] > 0) pend.push_back(r);
      if (pend.size() > 0 && $urandom_range(0, 29) != 0)
        wb_dest = lc3b_reg'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wb_dest = lc3b_reg'($urandom_range(0, 7));
      br_resolve = ($urandom_range(0, 3) == 0);
      #1;
      ed = id_ctrl.dest_mux_sel ? 3'd7 : id_dest;
      haz = (id_ctrl.uses_sr1 && m_cnt[id_sr1] != 0) ||
            (id_ctrl.uses_sr2 && m_cnt[id_sr2] != 0) ||
            (id_ctrl.load_regfile && m_cnt[ed] == MAXC);
      m_stall = id_valid && (haz || m_brw);
      m_iss   = id_valid && !m_stall;
      chk($sformatf("rnd%0d_issue", n), issue, m_iss);
      chk($sformatf("rnd%0d_stall", n), stall_id, m_stall);
      chk($sformatf("rnd%0d_fetch_hold", n), fetch_hold, m_brw);
      chk($sformatf("rnd%0d_sb_err", n), sb_err, m_err);
      // next-state rules
      wr_inc = m_iss && id_ctrl.load_regfile;
      wr_dec = wb_valid && wb_load_regfile;
      if (wr_dec && m_cnt[wb_dest] == 0) m_err = 1;
      if (!(wr_inc && wr_dec && ed == wb_dest)) begin
        if (wr_inc) m_cnt[ed] = m_cnt[ed] + 1;
        if (wr_dec && m_cnt[wb_dest] > 0) m_cnt[wb_dest] = m_cnt[wb_dest] - 1;
      end
      if (m_brw) begin
        if (br_resolve) m_brw = 0;
      end else if (m_iss && id_ctrl.branch) begin
        m_brw = 1;
      end
    end

`ifdef SCOREBOARD_STATS_EN
    // ---------------- stall statistics ----------------
    do_reset();
    #1;
    chk("stats_rst", stall_cycles, 16'h0000);
    @(negedge clk);
    drive(row(1, c_br, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(row(1, c_none, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    #1;
    chk("stats_five", stall_cycles, 16'd5);
    repeat (65535) @(negedge clk);
    #1;
    chk("stats_sat", stall_cycles, 16'hFFFF);
    @(negedge clk);
    #1;
    chk("stats_sat_hold", stall_cycles, 16'hFFFF);
`endif

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
